// File: rtl/serial_frame_rx_if.sv
// Parallel word handshake between serial_frame_rx (master) and its consumer (slave).
interface serial_frame_rx_if #(
  parameter int unsigned SHIFT_WIDTH = 8
);
  logic [SHIFT_WIDTH-1:0] data_out;
  logic                   data_valid;
  logic                   data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial-to-parallel receiver: start bit, SHIFT_WIDTH data bits, optional parity
// (SFRX_PARITY_EN), stop bit; good words land in a one-word buffer with valid/ready.
module serial_frame_rx #(
  parameter int unsigned SHIFT_WIDTH     = 8,
  parameter string       SHIFT_DIRECTION = "LEFT",
  parameter bit          PARITY_ODD      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclr,
  input  logic                     bit_en,
  input  logic                     serial_in,
  serial_frame_rx_if.master        bus,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     parity_err,
  output logic                     busy
);

  localparam int unsigned CntW      = $clog2(SHIFT_WIDTH);
  localparam bit          ShiftRight = (SHIFT_DIRECTION == "RIGHT");

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [SHIFT_WIDTH-1:0] data_q;
  logic                   valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
`ifdef SFRX_PARITY_EN
  logic                   par_bad_q;
  logic                   parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SFRX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else if (sclr) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SFRX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SFRX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Acceptance runs every cycle; a word loaded on the same edge overrides it below.
      if (valid_q && bus.data_ready) valid_q <= 1'b0;

      if (bit_en) begin
        unique case (state_q)
          StIdle: begin
            if (!serial_in) begin
              state_q <= StData;
              cnt_q   <= '0;
            end
          end
          StData: begin
            if (ShiftRight) shift_q <= {serial_in, shift_q[SHIFT_WIDTH-1:1]};
            else            shift_q <= {shift_q[SHIFT_WIDTH-2:0], serial_in};
            if (cnt_q == CntW'(SHIFT_WIDTH - 1)) begin
              cnt_q <= '0;
`ifdef SFRX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StParity: begin
`ifdef SFRX_PARITY_EN
            par_bad_q <= ((^shift_q) ^ serial_in) != PARITY_ODD;
`endif
            state_q <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (!serial_in) begin
              frame_err_q <= 1'b1;
`ifdef SFRX_PARITY_EN
            end else if (par_bad_q) begin
              parity_err_q <= 1'b1;
`endif
            end else if (!valid_q || bus.data_ready) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
`ifdef SFRX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != StIdle);
`ifdef SFRX_PARITY_EN
  assign parity_err     = parity_err_q;
`else
  assign parity_err     = 1'b0;
`endif

endmodule
